// File: rtl/mips_multi_control.sv
// mips_multi_control: main control FSM for a multicycle MIPS datapath.
// Moore-style strobes per state; memory states may stall on mem_ready.
module mips_multi_control #(
    parameter int ALU_CTRL_W = 4,
    parameter bit MEM_WAIT   = 1'b0,
    parameter int CNT_W      = 16,
    parameter bit EN_JUMP    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            Op,
    input  logic [5:0]            Funct,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  PC_write,
    output logic                  Mem_write,
    output logic                  lorD_mux,
    output logic                  IR_write,
    output logic                  Reg_Dst_mux,
    output logic                  Mem_reg_mux,
    output logic                  Reg_write,
    output logic                  ALU_srcA_mux,
    output logic                  Branch,
    output logic [1:0]            ALU_srcB_mux,
    output logic [1:0]            Pc_src_mux,
    output logic [ALU_CTRL_W-1:0] ALU_control,
    output logic [3:0]            state_o,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instr_count
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [3:0]       state;
    logic [3:0]       state_nx;
    logic [5:0]       op_q;
    logic [5:0]       funct_q;
    logic [CNT_W-1:0] cnt;
    logic             ready;
    logic [4:0]       fn_live;
    logic [4:0]       fn_cap;
    logic [3:0]       alu;
    logic             is_r;
    logic             is_mem;
    logic             is_beq;
    logic             is_addi;
    logic             is_j;
    logic             unused_zero;

    // Zero is consumed by the datapath (Branch & Zero), not by the FSM.
    assign unused_zero = Zero;

    assign ready = MEM_WAIT ? mem_ready : 1'b1;

    // {valid, ALU code} for an R-type function field.
    function automatic logic [4:0] alu_dec(input logic [5:0] f);
        logic [4:0] r;
        case (f)
            FN_ADD:  r = {1'b1, ALU_ADD};
            FN_SUB:  r = {1'b1, ALU_SUB};
            FN_AND:  r = {1'b1, ALU_AND};
            FN_OR:   r = {1'b1, ALU_OR};
            FN_SLT:  r = {1'b1, ALU_SLT};
            default: r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

    assign fn_live = alu_dec(Funct);
    assign fn_cap  = alu_dec(funct_q);

    assign is_r    = (Op == OP_R);
    assign is_mem  = (Op == OP_LW) || (Op == OP_SW);
    assign is_beq  = (Op == OP_BEQ);
    assign is_addi = (Op == OP_ADDI);
    assign is_j    = (Op == OP_J) && EN_JUMP;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH: begin
                if (ready)
                    state_nx = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:  state_nx = S_MEMADR;
                    is_r:    state_nx = fn_live[4] ? S_EXEC : S_ILLEGAL;
                    is_beq:  state_nx = S_BRANCH;
                    is_addi: state_nx = S_ADDIEX;
                    is_j:    state_nx = S_JUMP;
                    default: state_nx = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_nx = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (ready)
                    state_nx = S_MEMWB;
            end
            S_MEMWR: begin
                if (ready)
                    state_nx = S_FETCH;
            end
            S_EXEC:    state_nx = S_ALUWB;
            S_ADDIEX:  state_nx = S_ADDIWB;
            S_MEMWB,
            S_ALUWB,
            S_ADDIWB,
            S_BRANCH,
            S_JUMP:    state_nx = S_FETCH;
            S_ILLEGAL: state_nx = S_ILLEGAL;
            default:   state_nx = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                op_q    <= Op;
                funct_q <= Funct;
            end
            if (state == S_FETCH && ready)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Reset forces every output to its idle value in the same cycle.
    always_comb begin
        PC_write     = 1'b0;
        Mem_write    = 1'b0;
        lorD_mux     = 1'b0;
        IR_write     = 1'b0;
        Reg_Dst_mux  = 1'b0;
        Mem_reg_mux  = 1'b0;
        Reg_write    = 1'b0;
        ALU_srcA_mux = 1'b0;
        Branch       = 1'b0;
        ALU_srcB_mux = 2'b00;
        Pc_src_mux   = 2'b00;
        alu          = ALU_ADD;
        illegal      = 1'b0;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    ALU_srcB_mux = 2'b01;
                    IR_write     = ready;
                    PC_write     = ready;
                end
                S_DECODE: ALU_srcB_mux = 2'b11;
                S_MEMADR,
                S_ADDIEX: begin
                    ALU_srcA_mux = 1'b1;
                    ALU_srcB_mux = 2'b10;
                end
                S_MEMRD: lorD_mux = 1'b1;
                S_MEMWB: begin
                    Mem_reg_mux = 1'b1;
                    Reg_write   = 1'b1;
                end
                S_MEMWR: begin
                    lorD_mux  = 1'b1;
                    Mem_write = 1'b1;
                end
                S_EXEC: begin
                    ALU_srcA_mux = 1'b1;
                    alu          = fn_cap[3:0];
                end
                S_ALUWB: begin
                    Reg_Dst_mux = 1'b1;
                    Reg_write   = 1'b1;
                end
                S_BRANCH: begin
                    ALU_srcA_mux = 1'b1;
                    alu          = ALU_SUB;
                    Pc_src_mux   = 2'b01;
                    Branch       = 1'b1;
                end
                S_ADDIWB: Reg_write = 1'b1;
                S_JUMP: begin
                    Pc_src_mux = 2'b10;
                    PC_write   = 1'b1;
                end
                S_ILLEGAL: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign ALU_control = ALU_CTRL_W'(alu);
    assign state_o     = reset ? 4'd0 : state;
    assign instr_count = reset ? '0 : cnt;

endmodule

// File: tb/tb_mips_multi_control.sv
// tb_mips_multi_control: random instruction streams vs. per-opcode state walks.
// u0: stalling memory, jump enabled; u1: no stalls, jump disabled.
module tb_mips_multi_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       rst   [2];
    logic [5:0] op    [2];
    logic [5:0] fn    [2];
    logic       zero  [2];
    logic       mrdy  [2];
    logic       pcw   [2];
    logic       memw  [2];
    logic       lord  [2];
    logic       irw   [2];
    logic       rdst  [2];
    logic       mreg  [2];
    logic       regw  [2];
    logic       srca  [2];
    logic       brn   [2];
    logic [1:0] srcb  [2];
    logic [1:0] pcsrc [2];
    logic [3:0] aluc  [2];
    logic [3:0] st    [2];
    logic       ill   [2];
    logic [1:0] cnt   [2];

    int total = 0;
    int bad   = 0;
    int cnt_m [2];

    always #5 clk = ~clk;

    mips_multi_control #(.ALU_CTRL_W(4), .MEM_WAIT(1'b1), .CNT_W(2), .EN_JUMP(1'b1)) u0 (
        .clk(clk), .reset(rst[0]), .Op(op[0]), .Funct(fn[0]), .Zero(zero[0]),
        .mem_ready(mrdy[0]), .PC_write(pcw[0]), .Mem_write(memw[0]), .lorD_mux(lord[0]),
        .IR_write(irw[0]), .Reg_Dst_mux(rdst[0]), .Mem_reg_mux(mreg[0]),
        .Reg_write(regw[0]), .ALU_srcA_mux(srca[0]), .Branch(brn[0]),
        .ALU_srcB_mux(srcb[0]), .Pc_src_mux(pcsrc[0]), .ALU_control(aluc[0]),
        .state_o(st[0]), .illegal(ill[0]), .instr_count(cnt[0])
    );

    mips_multi_control #(.ALU_CTRL_W(4), .MEM_WAIT(1'b0), .CNT_W(2), .EN_JUMP(1'b0)) u1 (
        .clk(clk), .reset(rst[1]), .Op(op[1]), .Funct(fn[1]), .Zero(zero[1]),
        .mem_ready(mrdy[1]), .PC_write(pcw[1]), .Mem_write(memw[1]), .lorD_mux(lord[1]),
        .IR_write(irw[1]), .Reg_Dst_mux(rdst[1]), .Mem_reg_mux(mreg[1]),
        .Reg_write(regw[1]), .ALU_srcA_mux(srca[1]), .Branch(brn[1]),
        .ALU_srcB_mux(srcb[1]), .Pc_src_mux(pcsrc[1]), .ALU_control(aluc[1]),
        .state_o(st[1]), .illegal(ill[1]), .instr_count(cnt[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic int alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic logic [17:0] outv(input int d);
        return {pcw[d], memw[d], lord[d], irw[d], rdst[d], mreg[d], regw[d],
                srca[d], brn[d], srcb[d], pcsrc[d], aluc[d], ill[d]};
    endfunction

    // Expected strobes for a state, written straight from the per-state table.
    function automatic logic [17:0] exp_out(input int s, input bit rdy,
                                            input logic [5:0] fcap, input bit rs);
        logic pw, mw, ld, iw, rd, mr, rw, sa, br, il;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        {pw, mw, ld, iw, rd, mr, rw, sa, br, il} = '0;
        sb = 2'd0;
        ps = 2'd0;
        ac = 4'd2;
        if (!rs) begin
            case (s)
                0:  begin sb = 2'd1; iw = rdy; pw = rdy; end
                1:  sb = 2'd3;
                2, 9: begin sa = 1'b1; sb = 2'd2; end
                3:  ld = 1'b1;
                4:  begin mr = 1'b1; rw = 1'b1; end
                5:  begin ld = 1'b1; mw = 1'b1; end
                6:  begin sa = 1'b1; ac = 4'(alu_ref(fcap)); end
                7:  begin rd = 1'b1; rw = 1'b1; end
                8:  begin sa = 1'b1; ac = 4'd6; ps = 2'd1; br = 1'b1; end
                10: rw = 1'b1;
                11: begin ps = 2'd2; pw = 1'b1; end
                15: il = 1'b1;
                default: ;
            endcase
        end
        return {pw, mw, ld, iw, rd, mr, rw, sa, br, sb, ps, ac, il};
    endfunction

    function automatic iq_t build_seq(input int d, input logic [5:0] o, input logic [5:0] f);
        iq_t q;
        q = '{0, 1};
        if (o == OP_R && alu_ref(f) >= 0) begin q.push_back(6); q.push_back(7); end
        else if (o == OP_LW) begin q.push_back(2); q.push_back(3); q.push_back(4); end
        else if (o == OP_SW) begin q.push_back(2); q.push_back(5); end
        else if (o == OP_BEQ) q.push_back(8);
        else if (o == OP_ADDI) begin q.push_back(9); q.push_back(10); end
        else if (o == OP_J && d == 0) q.push_back(11);
        else q.push_back(15);
        return q;
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic step(input int d, input int s, input logic [5:0] o, input logic [5:0] f,
                        input logic [5:0] fcap, input bit m, input bit rs);
        bit rdy;
        rst[d]  = rs;
        op[d]   = o;
        fn[d]   = f;
        mrdy[d] = m;
        zero[d] = 1'($urandom);
        rdy = (d == 1) || m;
        @(negedge clk);
        check($sformatf("u%0d s%0d state", d, s), 32'(st[d]), rs ? 32'd0 : 32'(s));
        check($sformatf("u%0d s%0d outs", d, s), 32'(outv(d)), 32'(exp_out(s, rdy, fcap, rs)));
        check($sformatf("u%0d s%0d count", d, s), 32'(cnt[d]), rs ? 32'd0 : 32'(cnt_m[d]));
        @(posedge clk);
        #1;
        if (rs) cnt_m[d] = 0;
        else if (s == 0 && rdy) cnt_m[d] = (cnt_m[d] + 1) % 4;
    endtask

    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f);
        iq_t q;
        int  s;
        int  tries;
        bit  m;
        q = build_seq(d, o, f);
        foreach (q[i]) begin
            s = q[i];
            if (s == 15) begin
                repeat (20) step(d, 15, r6(), r6(), f, 1'($urandom), 1'b0);
            end else begin
                tries = 0;
                do begin
                    m = (tries >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    tries++;
                    step(d, s, (s <= 1) ? o : r6(), (s == 1) ? f : r6(), f, m, 1'b0);
                end while ((s == 0 || s == 3 || s == 5) && !(d == 1 || m));
            end
        end
    endtask

    task automatic rand_legal(input bit no_j, output logic [5:0] o, output logic [5:0] f);
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        o = ops[$urandom_range(0, no_j ? 4 : 5)];
        f = (o == OP_R) ? fns[$urandom_range(0, 4)] : r6();
    endtask

    task automatic do_reset(input int d);
        repeat (2) step(d, 0, r6(), r6(), 6'd0, 1'($urandom), 1'b1);
    endtask

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; op[d] = '0; fn[d] = '0; zero[d] = 1'b0; mrdy[d] = 1'b0;
            cnt_m[d] = 0;
        end
        @(posedge clk);
        #1;

        do_reset(0);
        run_instr(0, OP_R, 6'b100000);
        // lw with two stall cycles in FETCH and two in MEMRD: nine cycles total
        step(0, 0, OP_LW, r6(), 6'd0, 1'b0, 1'b0);
        step(0, 0, OP_LW, r6(), 6'd0, 1'b0, 1'b0);
        step(0, 0, OP_LW, r6(), 6'd0, 1'b1, 1'b0);
        step(0, 1, OP_LW, 6'd5, 6'd5, 1'b1, 1'b0);
        step(0, 2, r6(), r6(), 6'd5, 1'b1, 1'b0);
        step(0, 3, r6(), r6(), 6'd5, 1'b0, 1'b0);
        step(0, 3, r6(), r6(), 6'd5, 1'b0, 1'b0);
        step(0, 3, r6(), r6(), 6'd5, 1'b1, 1'b0);
        step(0, 4, r6(), r6(), 6'd5, 1'b1, 1'b0);
        run_instr(0, OP_BEQ, r6());
        repeat (5) run_instr(0, OP_J, r6());
        repeat (40) begin
            rand_legal(1'b0, o, f);
            run_instr(0, o, f);
        end
        run_instr(0, 6'b111111, r6());
        do_reset(0);
        // reset while a store is stalled in MEMWR
        step(0, 0, OP_SW, r6(), 6'd0, 1'b1, 1'b0);
        step(0, 1, OP_SW, r6(), 6'd0, 1'b1, 1'b0);
        step(0, 2, r6(), r6(), 6'd0, 1'b1, 1'b0);
        step(0, 5, r6(), r6(), 6'd0, 1'b0, 1'b0);
        step(0, 5, r6(), r6(), 6'd0, 1'b0, 1'b1);
        run_instr(0, OP_ADDI, r6());
        run_instr(0, OP_R, 6'b111000);
        do_reset(0);
        run_instr(0, OP_SW, r6());

        rst[0] = 1'b1;
        do_reset(1);
        repeat (20) begin
            rand_legal(1'b1, o, f);
            run_instr(1, o, f);
        end
        run_instr(1, OP_J, r6());
        do_reset(1);
        repeat (5) begin
            rand_legal(1'b1, o, f);
            run_instr(1, o, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multi_control.md
MIPS_MULTI_CONTROL -- requirements
Module: mips_multi_control

Interface
REQ-001 Parameter ALU_CTRL_W, default 4, is the width of ALU_control; minimum 4; codes are zero-extended to this width.
REQ-002 Parameter MEM_WAIT, default 0: 1 enables mem_ready stalling, 0 treats mem_ready as constant 1.
REQ-003 Parameter CNT_W, default 16, is the width of instr_count.
REQ-004 Parameter EN_JUMP, default 1: 0 makes opcode j illegal.
REQ-005 One clock; reset is synchronous and active-high; ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-006 Op  in  6  instruction opcode; Funct  in  6  R-type function field; Zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete.
REQ-007 Outputs, each 1 bit: PC_write, Mem_write, lorD_mux, IR_write, Reg_Dst_mux, Mem_reg_mux, Reg_write, ALU_srcA_mux, Branch.
REQ-008 Outputs: ALU_srcB_mux  out  2; Pc_src_mux  out  2 (00 ALU, 01 ALUOut, 10 jump target); ALU_control  out  ALU_CTRL_W.
REQ-009 Outputs: state_o  out  4  current state code; illegal  out  1  illegal-instruction flag; instr_count  out  CNT_W  retired fetch count.

Function
REQ-010 The block SHALL be a Moore FSM with state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=15.
REQ-011 Opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-012 Op and Funct SHALL be captured into internal registers on the DECODE cycle; later states use only the captured values.
REQ-013 Transitions: FETCH->DECODE when ready; DECODE->MEMADR (lw/sw), EXEC (R-type, legal Funct), BRANCH, ADDIEX, JUMP, else ILLEGAL; MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB when ready; MEMWR->FETCH when ready; EXEC->ALUWB; ADDIEX->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH; ILLEGAL->ILLEGAL.
REQ-014 "Ready" SHALL mean mem_ready=1 when MEM_WAIT=1, always true when MEM_WAIT=0.
REQ-015 All outputs not listed for a state SHALL be 0; ALU_control defaults to add (0010).
REQ-016 FETCH: lorD_mux=0, ALU_srcB_mux=01, Pc_src_mux=00; IR_write=1 and PC_write=1 only in the ready cycle.
REQ-017 DECODE: ALU_srcB_mux=11. MEMADR and ADDIEX: ALU_srcA_mux=1, ALU_srcB_mux=10.
REQ-018 MEMRD: lorD_mux=1. MEMWB: Mem_reg_mux=1, Reg_write=1. MEMWR: lorD_mux=1, Mem_write=1 every cycle in state. ADDIWB: Reg_write=1.
REQ-019 EXEC: ALU_srcA_mux=1, ALU_srcB_mux=00, ALU_control from Funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111; other Funct values SHALL route DECODE->ILLEGAL.
REQ-020 ALUWB: Reg_Dst_mux=1, Reg_write=1.
REQ-021 BRANCH: ALU_srcA_mux=1, ALU_srcB_mux=00, ALU_control=0110, Pc_src_mux=01, Branch=1; PC_write=0 (datapath combines Branch&Zero).
REQ-022 JUMP: Pc_src_mux=10, PC_write=1.
REQ-023 ILLEGAL: all strobes 0, illegal=1, held until reset.
REQ-024 instr_count SHALL increment by 1 on each FETCH->DECODE transition, wrapping from 2^CNT_W-1 to 0.
REQ-025 Latency with no stalls, FETCH to next FETCH: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles; each stall cycle adds 1.

Reset
REQ-026 On any clock edge with reset=1 the state SHALL become FETCH, instr_count 0, illegal 0, captured Op/Funct 0, regardless of current state.
REQ-027 While reset=1 all strobes (PC_write, IR_write, Mem_write, Reg_write, Branch) SHALL be driven 0; other outputs 0, ALU_control 0010.
REQ-028 Reset mid-instruction SHALL abandon the instruction with no further write strobes.

Verification
REQ-029 Op=000000, Funct=100000, MEM_WAIT=0 -> states 0,1,6,7,0; Reg_write=1 and Reg_Dst_mux=1 only in state 7; ALU_control=0010 in state 6.
REQ-030 lw, MEM_WAIT=1, mem_ready low 2 cycles in FETCH and MEMRD -> IR_write/PC_write pulse once on ready cycle; total 9 cycles; Mem_reg_mux=1 in MEMWB.
REQ-031 beq -> states 0,1,8,0; Branch=1, Pc_src_mux=01, ALU_control=0110 in state 8; PC_write=0 there.
REQ-032 Op=111111 -> DECODE then ILLEGAL; illegal=1, strobes 0 for 20 cycles; reset returns to FETCH with illegal=0.
REQ-033 Reset asserted in MEMWR with Mem_write=1 -> next cycle state_o=0, Mem_write=0, instr_count=0.
REQ-034 CNT_W=2, five j instructions, EN_JUMP=1 -> instr_count 1,2,3,0,1; EN_JUMP=0 -> j goes to ILLEGAL.
